// File: rtl/mil_rx_packet_assembler.sv
// MIL-STD-1553 receive packet assembler: buffers words between packet_start/packet_end
// and streams header + payload on a valid/ready interface; malformed packets are dropped.
module mil_rx_packet_assembler #(
    parameter int DEPTH = 33,
    parameter int CW    = 6
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    input  logic        in_cmd,
    input  logic        packet_start,
    input  logic        packet_end,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        err_overflow,
    output logic [7:0]  drop_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DROP, ST_EMIT} state_t;

    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

    state_t        r_state;
    logic [15:0]   r_buf [DEPTH];
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_idx;
    logic          r_cmd0;
    logic          r_cmd_or;
    logic          r_out_valid;
    logic [15:0]   r_out_data;
    logic          r_out_last;
    logic          r_err;
    logic [7:0]    r_drop;

    logic          w_store;
    logic          w_ovf;
    logic [CW-1:0] w_cnt_n;
    logic          w_cmd0_n;
    logic          w_cmd_or_n;
    logic [15:0]   w_hdr;
    logic          w_accept;
    logic          w_drop_inc;

    // Word handling is resolved before end/start so the header reflects a word
    // arriving in the same cycle as packet_end.
    always_comb begin
        w_store    = (r_state == ST_COLLECT) && in_valid && (r_count != LP_DEPTH);
        w_ovf      = (r_state == ST_COLLECT) && in_valid && (r_count == LP_DEPTH);
        w_cnt_n    = w_store ? r_count + CW'(1) : r_count;
        w_cmd0_n   = (w_store && r_count == '0) ? in_cmd : r_cmd0;
        w_cmd_or_n = w_store ? ((r_count == '0) ? 1'b0 : (r_cmd_or | in_cmd)) : r_cmd_or;
        w_hdr             = '0;
        w_hdr[15]         = w_cmd0_n;
        w_hdr[14]         = w_cmd_or_n;
        w_hdr[CW-1:0]     = w_cnt_n;
        w_accept   = r_out_valid && out_ready;
        w_drop_inc = 1'b0;
        case (r_state)
            ST_COLLECT: w_drop_inc = w_ovf || (packet_start && !packet_end)
                                     || (packet_start && packet_end && w_cnt_n != '0);
            ST_EMIT:    w_drop_inc = packet_start;
            default:    w_drop_inc = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_idx       <= '0;
            r_cmd0      <= 1'b0;
            r_cmd_or    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
            r_drop      <= '0;
        end else begin
            r_err <= w_ovf;
            if (w_store) r_buf[r_count] <= in_data;
            if (w_drop_inc && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;

            case (r_state)
                ST_IDLE: begin
                    if (packet_start) begin
                        r_state <= ST_COLLECT;
                        r_count <= '0;
                    end
                end
                ST_COLLECT: begin
                    r_count  <= w_cnt_n;
                    r_cmd0   <= w_cmd0_n;
                    r_cmd_or <= w_cmd_or_n;
                    if (w_ovf) begin
                        if (packet_end && packet_start) begin
                            r_count <= '0;
                        end else if (packet_end) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_DROP;
                        end
                    end else if (packet_end && w_cnt_n != '0) begin
                        r_state     <= ST_EMIT;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_hdr;
                        r_out_last  <= 1'b0;
                        r_idx       <= '0;
                    end else if (packet_end) begin
                        if (packet_start) r_count <= '0;
                        else              r_state <= ST_IDLE;
                    end else if (packet_start) begin
                        r_count <= '0;
                    end
                end
                ST_DROP: begin
                    if (packet_end) begin
                        r_state <= packet_start ? ST_COLLECT : ST_IDLE;
                        r_count <= '0;
                    end
                end
                ST_EMIT: begin
                    if (w_accept) begin
                        if (r_out_last) begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end else begin
                            r_out_data <= r_buf[r_idx];
                            r_out_last <= (r_idx == r_count - CW'(1));
                            r_idx      <= r_idx + CW'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    assign busy         = (r_state != ST_IDLE);
    assign err_overflow = r_err;
    assign drop_count   = r_drop;

endmodule
